// File: rtl/k12_fetch_if.sv
// ============================================================================
// Module   : k12_fetch_if
// Purpose  : Bundles the k12 fetch stage's memory bus, its instruction
//            handshake towards decode/ALU and its branch inputs.
// Ports    : master modport = fetch stage view, slave modport = memory plus
//            consumer view.
//            mem_addr/mem_req/mem_ack/mem_rdata  byte-wide memory bus
//            inst/inst_valid/inst_ready          instruction handshake
//            branch_en/branch_target/cond        branch resolution
//            pc                                  current instruction address
//            fault                               only with K12_FETCH_ALIGN_CHECK_EN
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface k12_fetch_if #(
  parameter int unsigned PC_WIDTH = 16
);
  logic [PC_WIDTH-1:0] mem_addr;
  logic                mem_req;
  logic                mem_ack;
  logic [7:0]          mem_rdata;
  logic [15:0]         inst;
  logic                inst_valid;
  logic                inst_ready;
  logic                branch_en;
  logic [PC_WIDTH-1:0] branch_target;
  logic                cond;
  logic [PC_WIDTH-1:0] pc;
`ifdef K12_FETCH_ALIGN_CHECK_EN
  logic                fault;

  modport master (
    output mem_addr, mem_req, inst, inst_valid, pc, fault,
    input  mem_ack, mem_rdata, inst_ready, branch_en, branch_target, cond
  );

  modport slave (
    input  mem_addr, mem_req, inst, inst_valid, pc, fault,
    output mem_ack, mem_rdata, inst_ready, branch_en, branch_target, cond
  );
`else
  modport master (
    output mem_addr, mem_req, inst, inst_valid, pc,
    input  mem_ack, mem_rdata, inst_ready, branch_en, branch_target, cond
  );

  modport slave (
    input  mem_addr, mem_req, inst, inst_valid, pc,
    output mem_ack, mem_rdata, inst_ready, branch_en, branch_target, cond
  );
`endif

endinterface

`default_nettype wire

// File: rtl/k12_fetch.sv
// ============================================================================
// Module   : k12_fetch
// Purpose  : k12 instruction fetch. Assembles a 16-bit instruction from two
//            byte reads (high byte at pc, low byte at pc+1), presents it with
//            a valid/ready handshake and updates pc at the handshake
//            (branch_target when branch_en & cond, otherwise pc+2).
// Ports    : clk  - clock, rising edge
//            rst  - synchronous active-high reset
//            bus  - k12_fetch_if.master (memory bus, instruction handshake,
//                   branch inputs, pc, optional fault)
// Options  : K12_FETCH_ALIGN_CHECK_EN - a taken branch to an odd target sets
//            a sticky fault and parks the stage in HALT until reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module k12_fetch #(
  parameter int unsigned         PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  wire logic clk,
  input  wire logic rst,
  k12_fetch_if.master bus
);

  localparam logic [1:0] c_FETCH_HI = 2'd0;
  localparam logic [1:0] c_FETCH_LO = 2'd1;
  localparam logic [1:0] c_HOLD     = 2'd2;
  localparam logic [1:0] c_HALT     = 2'd3;

  logic [1:0]          r_state;
  logic [1:0]          w_next;
  logic [PC_WIDTH-1:0] r_pc;
  logic [15:0]         r_inst;
  logic [PC_WIDTH-1:0] w_pc_inc1;
  logic [PC_WIDTH-1:0] w_pc_inc2;
  logic                w_hs;
  logic                w_taken;
  logic                w_misalign;

  // Natural truncation gives the modulo 2^PC_WIDTH wrap.
  assign w_pc_inc1 = r_pc + PC_WIDTH'(1);
  assign w_pc_inc2 = r_pc + PC_WIDTH'(2);

  assign w_hs    = (r_state == c_HOLD) && bus.inst_ready;
  assign w_taken = bus.branch_en && bus.cond;

`ifdef K12_FETCH_ALIGN_CHECK_EN
  assign w_misalign = w_hs && w_taken && bus.branch_target[0];
`else
  // Odd targets are simply fetched as byte pairs.
  assign w_misalign = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_FETCH_HI;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_FETCH_HI: if (bus.mem_ack) w_next = c_FETCH_LO;
      c_FETCH_LO: if (bus.mem_ack) w_next = c_HOLD;
      c_HOLD: begin
        if (w_hs) begin
          w_next = w_misalign ? c_HALT : c_FETCH_HI;
        end
      end
`ifdef K12_FETCH_ALIGN_CHECK_EN
      c_HALT:     w_next = c_HALT;
`endif
      default:    w_next = c_FETCH_HI;
    endcase
  end

  // Output logic; everything here decodes registered state only.
  always_comb begin
    bus.mem_req    = 1'b0;
    bus.mem_addr   = r_pc;
    bus.inst_valid = 1'b0;
    case (r_state)
      c_FETCH_HI: bus.mem_req = 1'b1;
      c_FETCH_LO: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = w_pc_inc1;
      end
      c_HOLD:     bus.inst_valid = 1'b1;
      default:    bus.mem_req = 1'b0;
    endcase
  end

  // Datapath: instruction bytes and program counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc   <= RESET_PC;
      r_inst <= 16'h0000;
    end else begin
      if ((r_state == c_FETCH_HI) && bus.mem_ack) begin
        r_inst[15:8] <= bus.mem_rdata;
      end
      if ((r_state == c_FETCH_LO) && bus.mem_ack) begin
        r_inst[7:0] <= bus.mem_rdata;
      end
      // A misaligned taken branch leaves pc at the faulting instruction.
      if (w_hs && !w_misalign) begin
        r_pc <= w_taken ? bus.branch_target : w_pc_inc2;
      end
    end
  end

  assign bus.inst = r_inst;
  assign bus.pc   = r_pc;

`ifdef K12_FETCH_ALIGN_CHECK_EN
  logic r_fault;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fault <= 1'b0;
    end else if (w_misalign) begin
      r_fault <= 1'b1;
    end
  end

  assign bus.fault = r_fault;
`endif

endmodule

`default_nettype wire

// File: tb/tb_k12_fetch.sv
// ============================================================================
// Module   : tb_k12_fetch
// Purpose  : Directed self-checking bench for k12_fetch. u0 starts at pc 0
//            and is stepped through fetch, wait states, stalls, branches and
//            reset; u1 starts at 16'hFFFE to exercise pc wrap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_k12_fetch;

  logic clk;
  logic rst;
  int   n_err;
  int   n_chk;

  logic [7:0] mem [0:255];

  k12_fetch_if #(.PC_WIDTH(16)) b0 ();
  k12_fetch_if #(.PC_WIDTH(16)) b1 ();

  k12_fetch #(.PC_WIDTH(16), .RESET_PC(16'h0000)) u0 (.clk(clk), .rst(rst), .bus(b0));
  k12_fetch #(.PC_WIDTH(16), .RESET_PC(16'hFFFE)) u1 (.clk(clk), .rst(rst), .bus(b1));

  // Zero-wait memory model; address low byte selects the entry.
  assign b0.mem_rdata = mem[b0.mem_addr[7:0]];
  assign b1.mem_rdata = mem[b1.mem_addr[7:0]];

  // u1 always acks and always accepts, never branches.
  assign b1.mem_ack       = 1'b1;
  assign b1.inst_ready    = 1'b1;
  assign b1.branch_en     = 1'b0;
  assign b1.branch_target = 16'h0000;
  assign b1.cond          = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // All checks and input changes happen on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    n_err = 0;
    n_chk = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h12; mem[8'h01] = 8'h34;
    mem[8'h02] = 8'h56; mem[8'h03] = 8'h78;
    mem[8'h40] = 8'hAB; mem[8'h41] = 8'hCD;
    mem[8'h42] = 8'hEF; mem[8'h43] = 8'h01;
    mem[8'hFE] = 8'h9A; mem[8'hFF] = 8'hBC;

    rst              = 1'b1;
    b0.mem_ack       = 1'b0;
    b0.inst_ready    = 1'b0;
    b0.branch_en     = 1'b0;
    b0.cond          = 1'b0;
    b0.branch_target = 16'h0000;
    tick();

    // Reset state
    rst = 1'b0;
    chk("rst_req",   b0.mem_req, 1);
    chk("rst_addr",  b0.mem_addr, 16'h0000);
    chk("rst_valid", b0.inst_valid, 0);
    chk("rst_inst",  b0.inst, 16'h0000);
    chk("rst_pc",    b0.pc, 16'h0000);
    chk("u1_rst_addr", b1.mem_addr, 16'hFFFE);
    chk("u1_rst_req",  b1.mem_req, 1);

    // Zero-wait fetch of 12,34
    b0.mem_ack = 1'b1;
    tick();
    chk("zw_lo_addr",  b0.mem_addr, 16'h0001);
    chk("zw_lo_req",   b0.mem_req, 1);
    chk("zw_lo_valid", b0.inst_valid, 0);
    chk("u1_lo_addr",  b1.mem_addr, 16'hFFFF);
    tick();
    chk("zw_valid", b0.inst_valid, 1);
    chk("zw_inst",  b0.inst, 16'h1234);
    chk("zw_req",   b0.mem_req, 0);
    chk("u1_inst",  b1.inst, 16'h9ABC);
    chk("u1_pc",    b1.pc, 16'hFFFE);
    b0.mem_ack = 1'b0;

    // Stall in HOLD for 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) begin
        chk("u1_wrap_pc",   b1.pc, 16'h0000);
        chk("u1_wrap_addr", b1.mem_addr, 16'h0000);
      end
      chk("stall_inst",  b0.inst, 16'h1234);
      chk("stall_pc",    b0.pc, 16'h0000);
      chk("stall_req",   b0.mem_req, 0);
      chk("stall_valid", b0.inst_valid, 1);
    end
    b0.inst_ready = 1'b1;
    tick();
    chk("adv_pc",    b0.pc, 16'h0002);
    chk("adv_addr",  b0.mem_addr, 16'h0002);
    chk("adv_valid", b0.inst_valid, 0);
    b0.inst_ready = 1'b0;

    // Three wait states on the low byte
    b0.mem_ack = 1'b1;
    tick();
    chk("ws_lo_addr", b0.mem_addr, 16'h0003);
    b0.mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ws_addr",  b0.mem_addr, 16'h0003);
      chk("ws_req",   b0.mem_req, 1);
      chk("ws_valid", b0.inst_valid, 0);
    end
    b0.mem_ack = 1'b1;
    tick();
    chk("ws_valid_rise", b0.inst_valid, 1);
    chk("ws_inst",       b0.inst, 16'h5678);

    // Taken branch to 0x0040
    b0.inst_ready    = 1'b1;
    b0.branch_en     = 1'b1;
    b0.cond          = 1'b1;
    b0.branch_target = 16'h0040;
    tick();
    chk("br_addr", b0.mem_addr, 16'h0040);
    chk("br_pc",   b0.pc, 16'h0040);
    // Branch inputs and ready during fetch must be ignored.
    b0.branch_target = 16'h0080;
    tick();
    chk("br_lo_addr", b0.mem_addr, 16'h0041);
    tick();
    chk("br_valid", b0.inst_valid, 1);
    chk("br_inst",  b0.inst, 16'hABCD);
    chk("br_hold_pc", b0.pc, 16'h0040);

    // Not-taken branch: pc+2
    b0.cond = 1'b0;
    tick();
    chk("nt_addr", b0.mem_addr, 16'h0042);
    chk("nt_pc",   b0.pc, 16'h0042);
    b0.branch_en = 1'b0;
    tick();
    tick();
    chk("nt_inst", b0.inst, 16'hEF01);

    // Reset in FETCH_LO together with mem_ack
    tick();
    chk("pre_rst_pc", b0.pc, 16'h0044);
    tick();
    chk("pre_rst_lo_addr", b0.mem_addr, 16'h0045);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_addr",  b0.mem_addr, 16'h0000);
    chk("mid_rst_req",   b0.mem_req, 1);
    chk("mid_rst_valid", b0.inst_valid, 0);
    chk("mid_rst_pc",    b0.pc, 16'h0000);
    chk("mid_rst_inst",  b0.inst, 16'h0000);

    // Fetch 1234 again, then take a branch to odd target 0x0041
    b0.inst_ready = 1'b0;
    tick();
    tick();
    chk("odd_pre_inst", b0.inst, 16'h1234);
    b0.inst_ready    = 1'b1;
    b0.branch_en     = 1'b1;
    b0.cond          = 1'b1;
    b0.branch_target = 16'h0041;
`ifdef K12_FETCH_ALIGN_CHECK_EN
    chk("fault_pre", b0.fault, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halt_fault", b0.fault, 1);
      chk("halt_req",   b0.mem_req, 0);
      chk("halt_valid", b0.inst_valid, 0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("halt_rst_fault", b0.fault, 0);
    chk("halt_rst_req",   b0.mem_req, 1);
`else
    tick();
    chk("odd_addr", b0.mem_addr, 16'h0041);
    chk("odd_pc",   b0.pc, 16'h0041);
    b0.inst_ready = 1'b0;
    b0.branch_en  = 1'b0;
    tick();
    chk("odd_lo_addr", b0.mem_addr, 16'h0042);
    tick();
    chk("odd_inst", b0.inst, 16'hCDEF);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/k12_fetch.md
# k12_fetch

Instruction fetch stage for the k12 core, directly upstream of the ALU. It reads 16-bit instructions as two byte-wide transfers from the 8-bit memory bus and presents each instruction on `inst` with a valid/ready handshake. It also maintains the program counter and applies taken branches using the ALU's `cond` output for the instruction being retired.

## Interface
- `PC_WIDTH`, default 16: program counter and memory address width.
- `RESET_PC`, default 0: PC value loaded on reset.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `mem_addr`  out  PC_WIDTH  byte address of the current transfer.
- `mem_req`  out  1  transfer request.
- `mem_ack`  in  1  transfer complete; `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  8  read data.
- `inst`  out  16  instruction to decode/ALU (`inst[15:8]` is the byte at PC; `inst[7:0]` is the byte at PC+1).
- `inst_valid`  out  1  `inst` holds a complete instruction.
- `inst_ready`  in  1  consumer accepts `inst` this cycle.
- `branch_en`  in  1  presented instruction is a conditional branch.
- `branch_target`  in  PC_WIDTH  branch destination.
- `cond`  in  1  ALU condition result for the presented instruction.
- `pc`  out  PC_WIDTH  address of the instruction currently fetched or presented.

## Operation
- The FSM has three states: `FETCH_HI`, `FETCH_LO`, `HOLD`.
- `FETCH_HI`:
  - Outputs are `mem_req`=1 and `mem_addr`=`pc`.
  - On `mem_ack`, latch `mem_rdata` into `inst[15:8]` and go to `FETCH_LO`.
- `FETCH_LO`:
  - Outputs are `mem_req`=1 and `mem_addr`=`pc`+1, computed modulo 2^PC_WIDTH.
  - On `mem_ack`, latch `mem_rdata` into `inst[7:0]` and go to `HOLD`.
- `HOLD`:
  - Outputs are `inst_valid`=1 and `mem_req`=0.
  - `inst` is stable until the handshake.
  - The handshake is the cycle with `inst_valid` and `inst_ready` both high.
- At the handshake:
  - If `branch_en` and `cond` are both 1, then `pc` ← `branch_target`.
  - Otherwise `pc` ← `pc`+2.
  - The FSM goes to `FETCH_HI`.
- `branch_en`, `branch_target` and `cond` are sampled only at the handshake and ignored in all other cycles.
- PC arithmetic is modulo 2^PC_WIDTH:
  - `pc` = 2^PC_WIDTH−2 advances to 0.
  - `pc` = 2^PC_WIDTH−1 fetches its low byte from address 0.
- Without `mem_ack`, the FSM stays in its fetch state with `mem_req` and `mem_addr` held stable for any number of wait states.
- `inst_ready` outside `HOLD` has no effect.

## Timing
- Reset values after a cycle with `rst`=1:
  - State is `FETCH_HI`, `pc`=`RESET_PC`, `inst`=16'h0000, `inst_valid`=0.
  - `mem_req`=1 and `mem_addr`=`RESET_PC`.
- `rst` overrides every other input, including `mem_ack` and handshakes in the same cycle.
- Reset mid-fetch abandons the transfer. The memory side must accept a request being dropped on reset.
- Zero-wait memory:
  - The high byte is acked in cycle N and the low byte in cycle N+1.
  - `inst_valid` rises in cycle N+2.
  - With `inst_ready` held high, the next high-byte request is in cycle N+3, giving 3 cycles per instruction.
- Each wait state adds exactly one cycle.
- `inst_valid` is registered and never asserts in a fetch state.

## Configuration
- `K12_FETCH_ALIGN_CHECK_EN` defined:
  - Adds output `fault` (1 bit, reset 0).
  - A taken branch with `branch_target[0]`=1 sets `fault`, which is sticky until reset.
  - The FSM then goes to a fourth state, `HALT`, with `mem_req`=0 and `inst_valid`=0, and stays there until reset.
- Not defined:
  - No `fault` port and no `HALT` state.
  - Odd targets are fetched as-is, as byte pairs at target and target+1.

## Test plan
- Reset, zero-wait memory, bytes 12,34 at address 0 → `inst_valid`=1 with `inst`=16'h1234 exactly 2 cycles after the first `mem_req`; `mem_addr` is 0 then 1.
- Hold `mem_ack`=0 for 3 cycles on the low byte → `mem_addr`=1 and `mem_req`=1 held stable for all 3 cycles; `inst_valid` rises one cycle after the ack.
- `inst_ready`=0 for 5 cycles in `HOLD` → `inst` and `pc` are unchanged; `mem_req`=0; on ready, `pc` advances 0→2.
- Handshake with `branch_en`=1, `cond`=1, target 16'h0040 → next `mem_addr`=16'h0040. Repeat with `cond`=0 → next `mem_addr`=`pc`+2.
- `RESET_PC`=16'hFFFE, then one handshake → low-byte fetch at 16'hFFFF, then `pc` wraps to 0.
- Assert `rst` in `FETCH_LO` together with `mem_ack` → the next cycle shows `FETCH_HI` with `mem_addr`=`RESET_PC` and `inst_valid`=0. With `K12_FETCH_ALIGN_CHECK_EN` defined, a taken branch to 16'h0041 → `fault`=1 and `mem_req`=0 until reset.
